// File: rtl/flags_register.sv
// Four-bit processor status flags (N, Z, C, V) held in flip-flops.
// Whole-register load on write_enable; asynchronous active-low reset to RESET_VALUE.
module flags_register #(
  parameter int unsigned          WIDTH       = 4,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic write_enable,
  input  logic d [WIDTH-1:0],
  output logic q [WIDTH-1:0]
);

  // q comes straight from the flops; the enable only steers their next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        q[i] <= RESET_VALUE[i];
      end
    end else if (write_enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        q[i] <= d[i];
      end
    end
  end

endmodule

// File: tb/tb_flags_register.sv
// Randomised scoreboard bench for flags_register: stimulus pushes the expected
// post-edge flags, a monitor pops and compares just after every rising edge.
`timescale 1ps / 1ps
module tb_flags_register;

  logic clk = 1'b0;
  logic rst;
  logic write_enable;
  logic d [3:0];
  logic q [3:0];

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];
  logic [3:0] mdl;  // flag value the register should currently hold

  flags_register #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .d            (d),
    .q            (q)
  );

  always #50 clk = ~clk;

  function automatic logic [3:0] pack(input logic a [3:0]);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: q=%b expected %b", name, $time, got, want);
    end
  endtask

  // Called 10 ps after an edge (or at start): drive inputs, predict the next edge,
  // and check mid-cycle that q has not moved (or has cleared if reset is asserted).
  task automatic cycle(input logic r, input logic we, input logic [3:0] dv);
    rst          = r;
    write_enable = we;
    for (int i = 0; i < 4; i++) d[i] = dv[i];
    if (!r) mdl = 4'b0000;
    #30;
    check("mid_cycle", pack(q), mdl);
    if (r && we) mdl = dv;
    exp_q.push_back(mdl);
    @(posedge clk);
    #10;
  endtask

  initial begin : monitor
    logic [3:0] want;
    forever begin
      @(posedge clk);
      #5;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL edge_no_expectation at %0t: q=%b expected none", $time, pack(q));
      end else begin
        want = exp_q.pop_front();
        check("edge", pack(q), want);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] walk [7];
    walk = '{4'b0000, 4'b0100, 4'b0010, 4'b0001, 4'b1010, 4'b0101, 4'b1111};
    rst          = 1'b1;
    write_enable = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 1'b0;
    mdl = 4'b0000;
    #5;

    // Reset held across two edges with a pending write.
    cycle(1'b0, 1'b1, 4'b1111);
    cycle(1'b0, 1'b1, 4'b1111);
    cycle(1'b1, 1'b1, 4'b1111);
    // Asynchronous reset mid-cycle after q=1111.
    cycle(1'b0, 1'b1, 4'b1111);

    foreach (walk[i]) cycle(1'b1, 1'b1, walk[i]);

    cycle(1'b1, 1'b1, 4'b1010);
    repeat (3) cycle(1'b1, 1'b0, 4'b0101);
    cycle(1'b1, 1'b1, 4'b0101);

    // Reset, then release between edges with write pending.
    cycle(1'b0, 1'b1, 4'b0110);
    cycle(1'b1, 1'b1, 4'b0110);

    repeat (200) begin
      cycle(($urandom_range(15) != 0), 1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    #20;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
